// File: rtl/hpdcache_mem_req_write_responder_if.sv
// Handshake and bus bundle for the write responder: metadata, data, memory and response channels.
// Signal suffixes are named from the responder's point of view.
interface hpdcache_mem_req_write_responder_if #(
  parameter int unsigned AW    = 64,
  parameter int unsigned DW    = 64,
  parameter int unsigned IDW   = 4,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned BEW = DW / 8;
  localparam int unsigned CW  = $clog2(DEPTH) + 1;

  logic             req_valid_i;
  logic             req_ready_o;
  logic [AW-1:0]    req_addr_i;
  logic [IDW-1:0]   req_id_i;

  logic             data_valid_i;
  logic             data_ready_o;
  logic [DW-1:0]    data_i;
  logic [BEW-1:0]   data_be_i;

  logic             mem_req_o;
  logic             mem_gnt_i;
  logic [AW-1:0]    mem_addr_o;
  logic [DW-1:0]    mem_wdata_o;
  logic [BEW-1:0]   mem_be_o;
  logic             mem_err_i;

  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [IDW-1:0]   resp_id_o;
  logic             resp_error_o;

  logic [CW-1:0]    pending_o;

  // Responder side
  modport slave (
    input  req_valid_i, req_addr_i, req_id_i,
    input  data_valid_i, data_i, data_be_i,
    input  mem_gnt_i, mem_err_i, resp_ready_i,
    output req_ready_o, data_ready_o,
    output mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output resp_valid_o, resp_id_o, resp_error_o, pending_o
  );

  // Requester / memory / response-consumer side
  modport master (
    output req_valid_i, req_addr_i, req_id_i,
    output data_valid_i, data_i, data_be_i,
    output mem_gnt_i, mem_err_i, resp_ready_i,
    input  req_ready_o, data_ready_o,
    input  mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  resp_valid_o, resp_id_o, resp_error_o, pending_o
  );
endinterface

// File: rtl/hpdcache_mem_req_write_responder.sv
// Pairs independently arriving write metadata and write data in order, issues memory writes
// and returns one registered response per granted write.
module hpdcache_mem_req_write_responder #(
  parameter int unsigned AW    = 64,
  parameter int unsigned DW    = 64,
  parameter int unsigned IDW   = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  hpdcache_mem_req_write_responder_if.slave bus
);
  localparam int unsigned BEW = DW / 8;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;

  logic [AW-1:0]  r_meta_addr [DEPTH];
  logic [IDW-1:0] r_meta_id   [DEPTH];
  logic [DW-1:0]  r_data      [DEPTH];
  logic [BEW-1:0] r_data_be   [DEPTH];

  logic [CW-1:0]  r_meta_wptr;
  logic [CW-1:0]  r_meta_rptr;
  logic [CW-1:0]  r_data_wptr;
  logic [CW-1:0]  r_data_rptr;

  logic           r_resp_valid;
  logic [IDW-1:0] r_resp_id;
  logic           r_resp_error;

  logic           w_meta_full;
  logic           w_meta_empty;
  logic           w_data_full;
  logic           w_data_empty;
  logic           w_meta_push;
  logic           w_data_push;
  logic           w_mem_req;
  logic           w_grant;
  logic [PW-1:0]  w_meta_widx;
  logic [PW-1:0]  w_meta_ridx;
  logic [PW-1:0]  w_data_widx;
  logic [PW-1:0]  w_data_ridx;

  assign w_meta_widx = r_meta_wptr[PW-1:0];
  assign w_meta_ridx = r_meta_rptr[PW-1:0];
  assign w_data_widx = r_data_wptr[PW-1:0];
  assign w_data_ridx = r_data_rptr[PW-1:0];

  // Full when the indexes match but the wrap bits differ; empty when pointers match.
  assign w_meta_full  = (w_meta_widx == w_meta_ridx) && (r_meta_wptr[PW] != r_meta_rptr[PW]);
  assign w_meta_empty = (r_meta_wptr == r_meta_rptr);
  assign w_data_full  = (w_data_widx == w_data_ridx) && (r_data_wptr[PW] != r_data_rptr[PW]);
  assign w_data_empty = (r_data_wptr == r_data_rptr);

  assign w_meta_push = bus.req_valid_i  && !w_meta_full;
  assign w_data_push = bus.data_valid_i && !w_data_full;

  // A write may only issue if the response register can take its result at the same edge.
  assign w_mem_req = !w_meta_empty && !w_data_empty && (!r_resp_valid || bus.resp_ready_i);
  assign w_grant   = w_mem_req && bus.mem_gnt_i;

  // Storage arrays carry no reset; only the pointers qualify their content.
  always_ff @(posedge clk_i) begin
    if (w_meta_push) begin
      r_meta_addr[w_meta_widx] <= bus.req_addr_i;
      r_meta_id[w_meta_widx]   <= bus.req_id_i;
    end
    if (w_data_push) begin
      r_data[w_data_widx]    <= bus.data_i;
      r_data_be[w_data_widx] <= bus.data_be_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta_wptr <= '0;
      r_meta_rptr <= '0;
      r_data_wptr <= '0;
      r_data_rptr <= '0;
    end else begin
      if (w_meta_push) r_meta_wptr <= r_meta_wptr + CW'(1);
      if (w_data_push) r_data_wptr <= r_data_wptr + CW'(1);
      if (w_grant) begin
        r_meta_rptr <= r_meta_rptr + CW'(1);
        r_data_rptr <= r_data_rptr + CW'(1);
      end
    end
  end

  // A grant always refills the response slot, even while the old response is being taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_error <= 1'b0;
    end else if (w_grant) begin
      r_resp_valid <= 1'b1;
      r_resp_id    <= r_meta_id[w_meta_ridx];
      r_resp_error <= bus.mem_err_i;
    end else if (r_resp_valid && bus.resp_ready_i) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign bus.req_ready_o  = !w_meta_full;
  assign bus.data_ready_o = !w_data_full;

  assign bus.mem_req_o    = w_mem_req;
  assign bus.mem_addr_o   = r_meta_addr[w_meta_ridx];
  assign bus.mem_wdata_o  = r_data[w_data_ridx];
  assign bus.mem_be_o     = r_data_be[w_data_ridx];

  assign bus.resp_valid_o = r_resp_valid;
  assign bus.resp_id_o    = r_resp_id;
  assign bus.resp_error_o = r_resp_error;

  assign bus.pending_o    = r_meta_wptr - r_meta_rptr;
endmodule

// File: tb/tb_hpdcache_mem_req_write_responder.sv
// Bench for the write responder: directed vector table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_hpdcache_mem_req_write_responder;
  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 64;
  localparam int unsigned IDW   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BEW   = DW / 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hpdcache_mem_req_write_responder_if #(.AW(AW), .DW(DW), .IDW(IDW), .DEPTH(DEPTH)) bus ();

  hpdcache_mem_req_write_responder #(.AW(AW), .DW(DW), .IDW(IDW), .DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic           rv;
    logic [AW-1:0]  addr;
    logic [IDW-1:0] id;
    logic           dv;
    logic [DW-1:0]  data;
    logic [BEW-1:0] be;
    logic           gnt;
    logic           err;
    logic           rr;
  } in_t;

  typedef struct {
    in_t            in;
    logic           rq_rdy;
    logic           d_rdy;
    logic           mreq;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [BEW-1:0] be;
    logic           rvld;
    logic [IDW-1:0] rid;
    logic           rerr;
    logic [CW-1:0]  pend;
  } vec_t;

  typedef struct packed { logic [AW-1:0] addr; logic [IDW-1:0] id; } meta_t;
  typedef struct packed { logic [DW-1:0] data; logic [BEW-1:0] be; } data_t;

  // Reference model: two plain queues and a single response slot.
  meta_t          mq[$];
  data_t          dq[$];
  logic           m_rv;
  logic [IDW-1:0] m_rid;
  logic           m_rerr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int grant_cnt;
  int first_grant;
  int last_grant;
  int pend_max;
  logic [DW-1:0]  wr_q[$];
  logic [IDW-1:0] resp_q[$];
  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic rv, input logic [AW-1:0] addr, input logic [IDW-1:0] id,
                             input logic dv, input logic [DW-1:0] data, input logic [BEW-1:0] be,
                             input logic gnt, input logic err, input logic rr);
    in_t v;
    v.rv = rv; v.addr = addr; v.id = id; v.dv = dv; v.data = data; v.be = be;
    v.gnt = gnt; v.err = err; v.rr = rr;
    return v;
  endfunction

  function automatic vec_t mkv(input in_t in, input logic rq_rdy, input logic d_rdy, input logic mreq,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [BEW-1:0] be, input logic rvld, input logic [IDW-1:0] rid,
                               input logic rerr, input logic [CW-1:0] pend);
    vec_t t;
    t.in = in; t.rq_rdy = rq_rdy; t.d_rdy = d_rdy; t.mreq = mreq; t.addr = addr; t.wdata = wdata;
    t.be = be; t.rvld = rvld; t.rid = rid; t.rerr = rerr; t.pend = pend;
    return t;
  endfunction

  task automatic drive(input in_t v);
    bus.req_valid_i  = v.rv;
    bus.req_addr_i   = v.addr;
    bus.req_id_i     = v.id;
    bus.data_valid_i = v.dv;
    bus.data_i       = v.data;
    bus.data_be_i    = v.be;
    bus.mem_gnt_i    = v.gnt;
    bus.mem_err_i    = v.err;
    bus.resp_ready_i = v.rr;
  endtask

  function automatic void model_clear();
    mq.delete();
    dq.delete();
    m_rv = 1'b0; m_rid = '0; m_rerr = 1'b0;
  endfunction

  function automatic logic model_mreq(input in_t v);
    return (mq.size() > 0) && (dq.size() > 0) && (!m_rv || v.rr);
  endfunction

  task automatic model_check(input in_t v);
    logic exp_mreq;
    exp_mreq = model_mreq(v);
    chk("req_ready",  64'(bus.req_ready_o),  64'(mq.size() < DEPTH));
    chk("data_ready", 64'(bus.data_ready_o), 64'(dq.size() < DEPTH));
    chk("mem_req",    64'(bus.mem_req_o),    64'(exp_mreq));
    if (exp_mreq) begin
      chk("mem_addr",  64'(bus.mem_addr_o),  64'(mq[0].addr));
      chk("mem_wdata", 64'(bus.mem_wdata_o), 64'(dq[0].data));
      chk("mem_be",    64'(bus.mem_be_o),    64'(dq[0].be));
    end
    chk("resp_valid", 64'(bus.resp_valid_o), 64'(m_rv));
    if (m_rv) begin
      chk("resp_id",    64'(bus.resp_id_o),    64'(m_rid));
      chk("resp_error", 64'(bus.resp_error_o), 64'(m_rerr));
    end
    chk("pending", 64'(bus.pending_o), 64'(mq.size()));
  endtask

  // Advance the model across one rising edge using pre-edge occupancy.
  function automatic void model_update(input in_t v);
    logic push_m, push_d, grant;
    push_m = v.rv && (mq.size() < DEPTH);
    push_d = v.dv && (dq.size() < DEPTH);
    grant  = model_mreq(v) && v.gnt;
    if (grant) begin
      m_rv = 1'b1; m_rid = mq[0].id; m_rerr = v.err;
      void'(mq.pop_front());
      void'(dq.pop_front());
    end else if (m_rv && v.rr) begin
      m_rv = 1'b0;
    end
    if (push_m) mq.push_back({v.addr, v.id});
    if (push_d) dq.push_back({v.data, v.be});
  endfunction

  // One cycle: drive at posedge+1, compare at negedge, then cross the next edge.
  task automatic step(input in_t v);
    drive(v);
    @(negedge clk);
    model_check(v);
    if (bus.mem_req_o && bus.mem_gnt_i) begin
      wr_q.push_back(bus.mem_wdata_o);
      if (first_grant < 0) first_grant = cyc;
      last_grant = cyc;
      grant_cnt++;
    end
    if (bus.resp_valid_o && bus.resp_ready_i) resp_q.push_back(bus.resp_id_o);
    if (int'(bus.pending_o) > pend_max) pend_max = int'(bus.pending_o);
    model_update(v);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_stats();
    grant_cnt = 0; first_grant = -1; last_grant = -1; pend_max = 0;
    wr_q.delete();
    resp_q.delete();
  endtask

  task automatic do_reset();
    drive(mk(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1));
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  64'(bus.req_ready_o),  64'd1);
    chk({tag, "_data_ready"}, 64'(bus.data_ready_o), 64'd1);
    chk({tag, "_mem_req"},    64'(bus.mem_req_o),    64'd0);
    chk({tag, "_resp_valid"}, 64'(bus.resp_valid_o), 64'd0);
    chk({tag, "_resp_id"},    64'(bus.resp_id_o),    64'd0);
    chk({tag, "_resp_error"}, 64'(bus.resp_error_o), 64'd0);
    chk({tag, "_pending"},    64'(bus.pending_o),    64'd0);
  endtask

  initial begin
    in_t idle;
    in_t v;
    idle = mk(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Directed table: metadata-first pairing, then a granted-late write with an error.
    tbl[0]  = mkv(mk(1, 64'h100, 4'd3, 0, '0, '0, 1, 0, 1), 1, 1, 0, '0, '0, '0, 0, '0, 0, 3'd0);
    tbl[1]  = mkv(idle, 1, 1, 0, '0, '0, '0, 0, '0, 0, 3'd1);
    tbl[2]  = mkv(idle, 1, 1, 0, '0, '0, '0, 0, '0, 0, 3'd1);
    tbl[3]  = mkv(idle, 1, 1, 0, '0, '0, '0, 0, '0, 0, 3'd1);
    tbl[4]  = mkv(mk(0, '0, '0, 1, 64'hDEADBEEF, 8'hFF, 1, 0, 1), 1, 1, 0, '0, '0, '0, 0, '0, 0, 3'd1);
    tbl[5]  = mkv(idle, 1, 1, 1, 64'h100, 64'hDEADBEEF, 8'hFF, 0, '0, 0, 3'd1);
    tbl[6]  = mkv(idle, 1, 1, 0, '0, '0, '0, 1, 4'd3, 0, 3'd0);
    tbl[7]  = mkv(idle, 1, 1, 0, '0, '0, '0, 0, '0, 0, 3'd0);
    tbl[8]  = mkv(mk(1, 64'h200, 4'd5, 1, 64'h1111, 8'h0F, 0, 0, 1), 1, 1, 0, '0, '0, '0, 0, '0, 0, 3'd0);
    tbl[9]  = mkv(mk(0, '0, '0, 0, '0, '0, 0, 0, 1), 1, 1, 1, 64'h200, 64'h1111, 8'h0F, 0, '0, 0, 3'd1);
    tbl[10] = mkv(mk(0, '0, '0, 0, '0, '0, 0, 0, 1), 1, 1, 1, 64'h200, 64'h1111, 8'h0F, 0, '0, 0, 3'd1);
    tbl[11] = mkv(mk(0, '0, '0, 0, '0, '0, 0, 0, 1), 1, 1, 1, 64'h200, 64'h1111, 8'h0F, 0, '0, 0, 3'd1);
    tbl[12] = mkv(mk(1, 64'h300, 4'd6, 1, 64'h2222, 8'hF0, 1, 1, 1), 1, 1, 1, 64'h200, 64'h1111, 8'h0F, 0, '0, 0, 3'd1);
    tbl[13] = mkv(mk(0, '0, '0, 0, '0, '0, 1, 0, 1), 1, 1, 1, 64'h300, 64'h2222, 8'hF0, 1, 4'd5, 1, 3'd1);
    tbl[14] = mkv(idle, 1, 1, 0, '0, '0, '0, 1, 4'd6, 0, 3'd0);
    tbl[15] = mkv(idle, 1, 1, 0, '0, '0, '0, 0, '0, 0, 3'd0);

    rst_n = 1'b0;
    drive(idle);
    model_clear();
    clear_stats();
    #2;
    chk_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].in);
      @(negedge clk);
      chk($sformatf("tbl%0d_req_ready", i),  64'(bus.req_ready_o),  64'(tbl[i].rq_rdy));
      chk($sformatf("tbl%0d_data_ready", i), 64'(bus.data_ready_o), 64'(tbl[i].d_rdy));
      chk($sformatf("tbl%0d_mem_req", i),    64'(bus.mem_req_o),    64'(tbl[i].mreq));
      if (tbl[i].mreq) begin
        chk($sformatf("tbl%0d_mem_addr", i),  64'(bus.mem_addr_o),  64'(tbl[i].addr));
        chk($sformatf("tbl%0d_mem_wdata", i), 64'(bus.mem_wdata_o), 64'(tbl[i].wdata));
        chk($sformatf("tbl%0d_mem_be", i),    64'(bus.mem_be_o),    64'(tbl[i].be));
      end
      chk($sformatf("tbl%0d_resp_valid", i), 64'(bus.resp_valid_o), 64'(tbl[i].rvld));
      if (tbl[i].rvld) begin
        chk($sformatf("tbl%0d_resp_id", i),    64'(bus.resp_id_o),    64'(tbl[i].rid));
        chk($sformatf("tbl%0d_resp_error", i), 64'(bus.resp_error_o), 64'(tbl[i].rerr));
      end
      chk($sformatf("tbl%0d_pending", i), 64'(bus.pending_o), 64'(tbl[i].pend));
      @(posedge clk);
      #1;
    end

    // Data-first overflow: fifth beat refused, writes carry beats 1..4 in order.
    do_reset();
    clear_stats();
    for (int k = 1; k <= 5; k++) begin
      step(mk(0, '0, '0, 1, 64'hA000 + 64'(k), 8'(k), 1, 0, 1));
      if (k == 4) chk("ovf_data_ready_low", 64'(bus.data_ready_o), 64'd0);
    end
    for (int k = 0; k < 4; k++) step(mk(1, 64'h1000 + 64'(k * 8), 4'(k), 0, '0, '0, 1, 0, 1));
    repeat (3) step(idle);
    chk("ovf_write_count", 64'(wr_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < wr_q.size(); k++)
      chk($sformatf("ovf_write%0d_data", k), 64'(wr_q[k]), 64'hA000 + 64'(k + 1));

    // Response stall: only one write until the consumer becomes ready.
    do_reset();
    clear_stats();
    step(mk(1, 64'h40, 4'd1, 1, 64'h11, 8'h01, 1, 0, 0));
    step(mk(1, 64'h48, 4'd2, 1, 64'h22, 8'h02, 1, 0, 0));
    repeat (5) step(mk(0, '0, '0, 0, '0, '0, 1, 0, 0));
    chk("stall_one_write", 64'(grant_cnt), 64'd1);
    chk("stall_resp_id_held", 64'(bus.resp_id_o), 64'd1);
    step(mk(0, '0, '0, 0, '0, '0, 1, 0, 1));
    chk("stall_second_write_on_ready", 64'(grant_cnt), 64'd2);
    repeat (2) step(idle);

    // Streaming across several pointer wraps.
    do_reset();
    clear_stats();
    for (int i = 0; i < 20; i++)
      step(mk(1, 64'h4000 + 64'(i * 8), 4'(i % 16), 1, 64'($urandom), 8'($urandom), 1, 0, 1));
    repeat (3) step(idle);
    chk("stream_writes", 64'(grant_cnt), 64'd20);
    chk("stream_consecutive", 64'(last_grant - first_grant), 64'd19);
    chk("stream_pending_max", 64'(pend_max), 64'd1);
    chk("stream_resp_count", 64'(resp_q.size()), 64'd20);
    for (int i = 0; i < 20 && i < resp_q.size(); i++)
      chk($sformatf("stream_resp%0d_id", i), 64'(resp_q[i]), 64'(i % 16));

    // Mid-operation reset with pairs and a response buffered.
    do_reset();
    clear_stats();
    step(mk(1, 64'h700, 4'd7, 1, 64'h77, 8'h77, 0, 0, 0));
    step(mk(1, 64'h800, 4'd8, 1, 64'h88, 8'h88, 0, 0, 0));
    step(mk(1, 64'h900, 4'd9, 1, 64'h99, 8'h99, 1, 0, 0));
    step(mk(1, 64'hA00, 4'd10, 1, 64'hAA, 8'hAA, 0, 0, 0));
    drive(idle);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    chk_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    clear_stats();
    repeat (5) step(idle);
    chk("midrst_no_write", 64'(grant_cnt), 64'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      v.rv   = ($urandom_range(0, 99) < 55);
      v.addr = {32'($urandom), 32'($urandom)};
      v.id   = 4'($urandom);
      v.dv   = ($urandom_range(0, 99) < 55);
      v.data = {32'($urandom), 32'($urandom)};
      v.be   = 8'($urandom);
      v.gnt  = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 75 : 30));
      v.err  = 1'($urandom);
      v.rr   = ($urandom_range(0, 99) < 70);
      step(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
